// File: rtl/ls374_bus_reader.sv
// Read-side scanner for a bank of LS374-style tri-state latches sharing one 8-bit bus.
// Enables one latch at a time, waits for the bus to settle, then hands the byte off via valid/ready.
module ls374_bus_reader #(
   parameter int NUM_SRC = 4,
   parameter int SETTLE  = 1,
   localparam int IDX_W  = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         bus_in,
   output logic [NUM_SRC-1:0] oe_n,
   output logic [7:0]         data_out,
   output logic [IDX_W-1:0]   data_idx,
   output logic               data_valid,
   input  logic               data_ready,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ENABLE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SRC - 1);
   localparam logic [NUM_SRC-1:0] FIRST_OE = {{(NUM_SRC-1){1'b1}}, 1'b0};

   logic [1:0]       state;
   logic [3:0]       settle_cnt;
   // scan_idx walks the latches; data_idx only changes when a byte is captured,
   // so it always labels data_out even after an abort.
   logic [IDX_W-1:0] scan_idx;
   logic [IDX_W-1:0] scan_idx_inc;

   assign scan_idx_inc = scan_idx + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= 4'd0;
         scan_idx   <= '0;
         oe_n       <= '1;
         data_out   <= 8'h00;
         data_idx   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  scan_idx   <= '0;
                  oe_n       <= FIRST_OE;
                  settle_cnt <= SETTLE_CNT;
                  busy       <= 1'b1;
                  state      <= ENABLE;
               end
            end
            ENABLE: begin
               if (abort) begin
                  oe_n  <= '1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (settle_cnt != 4'd0) begin
                  settle_cnt <= settle_cnt - 4'd1;
               end else begin
                  data_out   <= bus_in;
                  data_idx   <= scan_idx;
                  data_valid <= 1'b1;
                  oe_n       <= '1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               // An accept coinciding with abort still delivers the byte, but no done.
               if (abort) begin
                  data_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if (data_valid && data_ready) begin
                  data_valid <= 1'b0;
                  if (scan_idx == LAST_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     scan_idx   <= scan_idx_inc;
                     oe_n       <= ~(NUM_SRC'(1) << scan_idx_inc);
                     settle_cnt <= SETTLE_CNT;
                     state      <= ENABLE;
                  end
               end
            end
            default: begin
               oe_n       <= '1;
               data_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
